// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding-request fetch stage feeding an IF/ID register.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req, imem_addr        request to instruction memory (addr word aligned)
//   imem_ready                 memory accepts the request this cycle
//   imem_rvalid, imem_rdata    one response pulse per accepted request
//   stall                      decode cannot take a new instruction; IF/ID holds
//   redirect_valid, redirect_pc taken branch/jump; fetch restarts at redirect_pc
//   pc, pc_next, instruction, instr_valid  IF/ID register (instr_valid=0 is a bubble)
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic [31:0] instruction,
    output logic        instr_valid
);
    typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;
    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] hold_pc;
    logic [31:0] hold_word;
    logic        drop;
    logic [31:0] target;
    assign target    = redirect_pc & ~32'h3;
    assign imem_addr = fetch_pc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            imem_req    <= 1'b0;
            fetch_pc    <= RESET_PC;
            hold_pc     <= 32'h0;
            hold_word   <= 32'h0;
            drop        <= 1'b0;
            pc          <= 32'h0;
            pc_next     <= 32'h0;
            instruction <= 32'h0000_0013;
            instr_valid <= 1'b0;
        end else begin
            // bubble whenever decode is free; a load below overrides this
            if (!stall) instr_valid <= 1'b0;
            if (redirect_valid) begin
                instr_valid <= 1'b0;
                fetch_pc    <= target;
                case (state)
                    REQ: if (imem_ready) begin
                        // request already accepted for the old path: drop its response
                        state    <= WAIT;
                        imem_req <= 1'b0;
                        drop     <= 1'b1;
                    end
                    WAIT: if (imem_rvalid) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                        drop     <= 1'b0;
                    end else begin
                        drop <= 1'b1;
                    end
                    default: begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                endcase
            end else begin
                case (state)
                    BOOT: begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                    REQ: if (imem_ready) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                    end
                    WAIT: if (imem_rvalid) begin
                        if (drop) begin
                            drop     <= 1'b0;
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end else if (stall) begin
                            hold_pc   <= fetch_pc;
                            hold_word <= imem_rdata;
                            state     <= HOLD;
                        end else begin
                            pc          <= fetch_pc;
                            pc_next     <= fetch_pc + 32'd4;
                            instruction <= imem_rdata;
                            instr_valid <= 1'b1;
                            fetch_pc    <= fetch_pc + 32'd4;
                            state       <= REQ;
                            imem_req    <= 1'b1;
                        end
                    end
                    HOLD: if (!stall) begin
                        pc          <= hold_pc;
                        pc_next     <= hold_pc + 32'd4;
                        instruction <= hold_word;
                        instr_valid <= 1'b1;
                        fetch_pc    <= hold_pc + 32'd4;
                        state       <= REQ;
                        imem_req    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
